// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit and the datapath ALU: opcodes, FSM states,
// ALU op selects and the packed control word.
package control_unit_pkg;

   typedef enum logic [3:0] {
      ST_RESET, ST_T0, ST_T1, ST_T1W, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = 5'b00011;

   typedef struct packed {
      logic run;
      logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc, con_in;
      logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
      logic read, write, gra, grb, grc, rin, rout, ba_out;
      logic [4:0] alu;
   } ctrl_t;

   function automatic logic is_reg_alu(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_SHL);
   endfunction

   function automatic logic is_imm(input logic [4:0] op);
      return op inside {OP_ADDI, OP_ANDI, OP_ORI};
   endfunction

   function automatic logic is_mem(input logic [4:0] op);
      return op inside {OP_LD, OP_LDI, OP_ST};
   endfunction

   // Opcodes that run past T2; everything else (nop, jal, unused codes) refetches.
   function automatic logic has_exec(input logic [4:0] op);
      return (op <= OP_NOT) || (op inside {OP_BR, OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO});
   endfunction

endpackage

// File: rtl/control_unit.sv
// Moore sequencer for the CPU datapath: fetch, decode and per-opcode execute steps.
//   state    | meaning
//   RESET    | clr held low, all outputs low
//   T0       | PC to MAR, increment PC
//   T1/T1W   | instruction read, T1W repeats until the wait count expires
//   T2       | MDR to IR, opcode captured
//   T3..T7   | execute steps, meaning depends on the captured opcode
//   HALT     | idle until reset
module control_unit
   import control_unit_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR_Data,
   input  logic        CON_out,
   input  logic        stop,
   output logic        run,
   output logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in,
   output logic        PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
   output logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [4:0]  alu_instruction_bits
);

   localparam logic [1:0] WAIT_LOAD = 2'(MEM_WAIT - 1);

   state_e     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [4:0] op_q, op_d;
   logic       br_q, br_d;
   logic       stop_q, stop_d;
   logic       done;
   ctrl_t      ctrl;

   logic [4:0] ir_op;
   logic       unused_ir;
   assign ir_op     = IR_Data[31:27];
   assign unused_ir = ^IR_Data[26:0];

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         op_q    <= '0;
         br_q    <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         br_q    <= br_d;
         stop_q  <= stop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      br_d     = br_q;
      done     = 1'b0;
      ctrl     = '0;
      ctrl.run = (state_q != ST_RESET) && (state_q != ST_HALT);
      case (state_q)
         ST_RESET: state_d = ST_T0;
         ST_T0: begin
            ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1;
            cnt_d   = WAIT_LOAD;
            state_d = ST_T1;
         end
         ST_T1, ST_T1W: begin
            ctrl.read   = 1'b1;
            ctrl.mdr_in = (cnt_q == 2'd0);
            if (cnt_q == 2'd0) state_d = ST_T2;
            else begin
               cnt_d   = cnt_q - 2'd1;
               state_d = ST_T1W;
            end
         end
         ST_T2: begin
            ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
            op_d = ir_op;
            if (ir_op == OP_HALT)    state_d = ST_HALT;
            else if (has_exec(ir_op)) state_d = ST_T3;
            else                      done = 1'b1;
         end
         ST_T3: begin
            state_d = ST_T4;
            if (is_reg_alu(op_q) || is_imm(op_q)) begin
               ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
            end else if (op_q inside {OP_MUL, OP_DIV}) begin
               ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1;
            end else if (op_q inside {OP_NEG, OP_NOT}) begin
               ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op_q;
            end else if (is_mem(op_q)) begin
               ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
            end else if (op_q == OP_BR) begin
               ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1;
            end else begin
               done = 1'b1;
               case (op_q)
                  OP_JR:   begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; end
                  OP_IN:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                  OP_OUT:  begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outport_in = 1'b1; end
                  OP_MFHI: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                  OP_MFLO: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                  default: ;
               endcase
            end
         end
         ST_T4: begin
            state_d = ST_T5;
            if (is_reg_alu(op_q)) begin
               ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op_q;
            end else if (is_imm(op_q)) begin
               ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op_q;
            end else if (op_q inside {OP_MUL, OP_DIV}) begin
               ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = op_q;
            end else if (op_q inside {OP_NEG, OP_NOT}) begin
               ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
               done = 1'b1;
            end else if (is_mem(op_q)) begin
               ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = ALU_ADD;
            end else if (op_q == OP_BR) begin
               ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1;
            end else done = 1'b1;
         end
         ST_T5: begin
            state_d = ST_T6;
            if (is_reg_alu(op_q) || is_imm(op_q) || op_q == OP_LDI) begin
               ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
               done = 1'b1;
            end else if (op_q inside {OP_MUL, OP_DIV}) begin
               ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1;
            end else if (op_q inside {OP_LD, OP_ST}) begin
               ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1;
               cnt_d = WAIT_LOAD;
            end else if (op_q == OP_BR) begin
               ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = ALU_ADD;
               br_d = CON_out;
            end else done = 1'b1;
         end
         ST_T6: begin
            if (op_q inside {OP_MUL, OP_DIV}) begin
               ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1;
               done = 1'b1;
            end else if (op_q == OP_LD) begin
               ctrl.read   = 1'b1;
               ctrl.mdr_in = (cnt_q == 2'd0);
               if (cnt_q == 2'd0) state_d = ST_T7;
               else               cnt_d   = cnt_q - 2'd1;
            end else if (op_q == OP_ST) begin
               ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1;
               state_d = ST_T7;
            end else if (op_q == OP_BR) begin
               ctrl.zlow_out = 1'b1; ctrl.pc_in = br_q;
               done = 1'b1;
            end else done = 1'b1;
         end
         ST_T7: begin
            if (op_q == OP_LD) begin
               ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
            end else if (op_q == OP_ST) ctrl.write = 1'b1;
            done = 1'b1;
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_RESET;
      endcase
      if (done) state_d = (stop_q || stop) ? ST_HALT : ST_T0;
      // A stop request sticks until the instruction that saw it has retired.
      stop_d = ctrl.run && (stop_q || stop) && (state_d != ST_T0);
   end

   assign run                  = ctrl.run;
   assign PC_in                = ctrl.pc_in;
   assign IR_in                = ctrl.ir_in;
   assign Y_in                 = ctrl.y_in;
   assign Z_in                 = ctrl.z_in;
   assign HI_in                = ctrl.hi_in;
   assign LO_in                = ctrl.lo_in;
   assign MAR_in               = ctrl.mar_in;
   assign MDR_in               = ctrl.mdr_in;
   assign OutPort_in           = ctrl.outport_in;
   assign IncPC                = ctrl.inc_pc;
   assign CON_in               = ctrl.con_in;
   assign PC_out               = ctrl.pc_out;
   assign Zhigh_out            = ctrl.zhigh_out;
   assign Zlow_out             = ctrl.zlow_out;
   assign HI_out               = ctrl.hi_out;
   assign LO_out               = ctrl.lo_out;
   assign MDR_out              = ctrl.mdr_out;
   assign InPort_out           = ctrl.inport_out;
   assign C_out                = ctrl.c_out;
   assign Read                 = ctrl.read;
   assign Write                = ctrl.write;
   assign Gra                  = ctrl.gra;
   assign Grb                  = ctrl.grb;
   assign Grc                  = ctrl.grc;
   assign Rin                  = ctrl.rin;
   assign Rout                 = ctrl.rout;
   assign BAout                = ctrl.ba_out;
   assign alu_instruction_bits = ctrl.alu;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench: two control units (MEM_WAIT 1 and 3) share stimulus; each cycle's
// strobe word is compared against hand-built expected words.
module tb_control_unit;

   localparam logic [32:0] RUN     = 33'd1 << 32;
   localparam logic [32:0] PC_IN   = 33'd1 << 31;
   localparam logic [32:0] IR_IN   = 33'd1 << 30;
   localparam logic [32:0] Y_IN    = 33'd1 << 29;
   localparam logic [32:0] Z_IN    = 33'd1 << 28;
   localparam logic [32:0] HI_IN   = 33'd1 << 27;
   localparam logic [32:0] LO_IN   = 33'd1 << 26;
   localparam logic [32:0] MAR_IN  = 33'd1 << 25;
   localparam logic [32:0] MDR_IN  = 33'd1 << 24;
   localparam logic [32:0] INC_PC  = 33'd1 << 22;
   localparam logic [32:0] CON_IN  = 33'd1 << 21;
   localparam logic [32:0] PC_OUT  = 33'd1 << 20;
   localparam logic [32:0] ZH_OUT  = 33'd1 << 19;
   localparam logic [32:0] ZL_OUT  = 33'd1 << 18;
   localparam logic [32:0] HI_OUT  = 33'd1 << 17;
   localparam logic [32:0] MDR_OUT = 33'd1 << 15;
   localparam logic [32:0] C_OUT   = 33'd1 << 13;
   localparam logic [32:0] READ    = 33'd1 << 12;
   localparam logic [32:0] WRITE   = 33'd1 << 11;
   localparam logic [32:0] GRA     = 33'd1 << 10;
   localparam logic [32:0] GRB     = 33'd1 << 9;
   localparam logic [32:0] GRC     = 33'd1 << 8;
   localparam logic [32:0] RIN     = 33'd1 << 7;
   localparam logic [32:0] ROUT    = 33'd1 << 6;
   localparam logic [32:0] BA_OUT  = 33'd1 << 5;
   localparam logic [32:0] A_ADD   = 33'h03;
   localparam logic [32:0] A_MUL   = 33'h0F;
   localparam logic [32:0] IDLE    = 33'd0;

   logic        clk = 1'b0;
   logic        clr;
   logic [31:0] IR_Data;
   logic        CON_out;
   logic        stop;
   logic [32:0] obs [2];
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC, CON_in;
      logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
      logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
      logic [4:0] alu;
      control_unit #(.MEM_WAIT(g == 0 ? 1 : 3)) u_dut (
         .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out), .stop(stop),
         .run(run), .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in),
         .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in),
         .IncPC(IncPC), .CON_in(CON_in), .PC_out(PC_out), .Zhigh_out(Zhigh_out),
         .Zlow_out(Zlow_out), .HI_out(HI_out), .LO_out(LO_out), .MDR_out(MDR_out),
         .InPort_out(InPort_out), .C_out(C_out), .Read(Read), .Write(Write), .Gra(Gra),
         .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
         .alu_instruction_bits(alu)
      );
      assign obs[g] = {run, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in,
                       IncPC, CON_in, PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out,
                       InPort_out, C_out, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu};
   end

   task automatic check_eq(input string tag, input logic [32:0] act, input logic [32:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int inst, input string tag, input logic [32:0] exp);
      @(negedge clk);
      check_eq(tag, obs[inst], exp);
   endtask

   task automatic do_reset(input logic [31:0] ir);
      @(negedge clk);
      clr     = 1'b0;
      IR_Data = ir;
      @(negedge clk);
      check_eq("rst_mw1", obs[0], IDLE);
      check_eq("rst_mw3", obs[1], IDLE);
      clr = 1'b1;
   endtask

   task automatic fetch(input int inst, input int mw);
      cyc(inst, "t0", RUN | PC_OUT | MAR_IN | INC_PC);
      for (int i = 0; i < mw; i++)
         cyc(inst, "t1_read", RUN | READ | ((i == mw - 1) ? MDR_IN : IDLE));
      cyc(inst, "t2", RUN | MDR_OUT | IR_IN);
   endtask

   initial begin
      clr = 1'b0; stop = 1'b1; CON_out = 1'b0; IR_Data = 32'h1891_8000;
      repeat (2) @(negedge clk);
      check_eq("rst_stop_mw1", obs[0], IDLE);
      check_eq("rst_stop_mw3", obs[1], IDLE);
      stop = 1'b0;

      // add R1,R2,R3 with MEM_WAIT=1; back at T0 on the seventh cycle
      do_reset(32'h1891_8000);
      fetch(0, 1);
      cyc(0, "add_t3", RUN | GRB | ROUT | Y_IN);
      cyc(0, "add_t4", RUN | GRC | ROUT | Z_IN | A_ADD);
      cyc(0, "add_t5", RUN | ZL_OUT | GRA | RIN);
      cyc(0, "add_next_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // ld R1,0x10(R2) with MEM_WAIT=3
      do_reset(32'h0090_0010);
      fetch(1, 3);
      cyc(1, "ld_t3", RUN | GRB | BA_OUT | Y_IN);
      cyc(1, "ld_t4", RUN | C_OUT | Z_IN | A_ADD);
      cyc(1, "ld_t5", RUN | ZL_OUT | MAR_IN);
      cyc(1, "ld_t6a", RUN | READ);
      cyc(1, "ld_t6b", RUN | READ);
      cyc(1, "ld_t6c", RUN | READ | MDR_IN);
      cyc(1, "ld_t7", RUN | MDR_OUT | GRA | RIN);
      cyc(1, "ld_next_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // branch not taken: CON high around T4 but low at the end of T5
      do_reset(32'h9880_0000);
      fetch(0, 1);
      cyc(0, "br_t3", RUN | GRA | ROUT | CON_IN);
      CON_out = 1'b1;
      cyc(0, "br_t4", RUN | PC_OUT | Y_IN);
      CON_out = 1'b0;
      cyc(0, "br_t5", RUN | C_OUT | Z_IN | A_ADD);
      cyc(0, "br_nt_t6", RUN | ZL_OUT);
      cyc(0, "br_nt_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // branch taken: CON high only at the end of T5
      do_reset(32'h9880_0000);
      fetch(0, 1);
      cyc(0, "brt_t3", RUN | GRA | ROUT | CON_IN);
      cyc(0, "brt_t4", RUN | PC_OUT | Y_IN);
      cyc(0, "brt_t5", RUN | C_OUT | Z_IN | A_ADD);
      CON_out = 1'b1;
      cyc(0, "br_tk_t6", RUN | ZL_OUT | PC_IN);
      CON_out = 1'b0;
      cyc(0, "br_tk_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // mul with a one-cycle stop in T4: finishes, then halts
      do_reset(32'h7918_0000);
      fetch(0, 1);
      cyc(0, "mul_t3", RUN | GRA | ROUT | Y_IN);
      cyc(0, "mul_t4", RUN | GRB | ROUT | Z_IN | A_MUL);
      stop = 1'b1;
      cyc(0, "mul_t5", RUN | ZL_OUT | LO_IN);
      stop = 1'b0;
      cyc(0, "mul_t6", RUN | ZH_OUT | HI_IN);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) stop = 1'b1;
         if (i == 8) stop = 1'b0;
         cyc(0, "mul_halt", IDLE);
      end

      // st once to completion, then again with clr dropped in T6
      do_reset(32'h1090_0020);
      for (int pass = 0; pass < 2; pass++) begin
         fetch(0, 1);
         cyc(0, "st_t3", RUN | GRB | BA_OUT | Y_IN);
         cyc(0, "st_t4", RUN | C_OUT | Z_IN | A_ADD);
         cyc(0, "st_t5", RUN | ZL_OUT | MAR_IN);
         cyc(0, "st_t6", RUN | GRA | ROUT | MDR_IN);
         if (pass == 0) cyc(0, "st_t7", RUN | WRITE);
      end
      clr = 1'b0;
      cyc(0, "st_clr_reset", IDLE);
      clr = 1'b1;
      cyc(0, "st_clr_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // halt opcode goes straight to HALT after T2
      do_reset(32'hD800_0000);
      fetch(0, 1);
      cyc(0, "halt_a", IDLE);
      cyc(0, "halt_b", IDLE);

      // undefined opcode (jal slot) refetches immediately
      do_reset(32'hA800_0000);
      fetch(0, 1);
      cyc(0, "undef_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // nop with stop pulsed at the end of T0 still halts after T2
      do_reset(32'hD000_0000);
      cyc(0, "nop_t0", RUN | PC_OUT | MAR_IN | INC_PC);
      stop = 1'b1;
      cyc(0, "nop_t1", RUN | READ | MDR_IN);
      stop = 1'b0;
      cyc(0, "nop_t2", RUN | MDR_OUT | IR_IN);
      cyc(0, "nop_stop_halt", IDLE);

      // mfhi R3 with MEM_WAIT=3
      do_reset(32'hC180_0000);
      fetch(1, 3);
      cyc(1, "mfhi_t3", RUN | HI_OUT | GRA | RIN);
      cyc(1, "mfhi_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      // clr during the instruction-read wait
      do_reset(32'h0090_0010);
      cyc(1, "mid_t0", RUN | PC_OUT | MAR_IN | INC_PC);
      cyc(1, "mid_t1", RUN | READ);
      cyc(1, "mid_t1w", RUN | READ);
      clr = 1'b0;
      cyc(1, "mid_read_reset", IDLE);
      clr = 1'b1;
      cyc(1, "mid_read_t0", RUN | PC_OUT | MAR_IN | INC_PC);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
